// File: rtl/sd_cmd_phy_pkg.sv
// Shared types and constants for the SD CMD-line framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: response-type and FSM state encodings, CRC7 polynomial, frame lengths.
package sd_cmd_phy_pkg;

   typedef enum logic [1:0] {
      RESP_NONE = 2'b00,
      RESP_48   = 2'b01,
      RESP_136  = 2'b10,
      RESP_RSVD = 2'b11   // behaves like RESP_NONE
   } resp_type_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_TX,
      ST_TAIL,
      ST_WAIT_RESP,
      ST_RX,
      ST_DONE
   } state_e;

   // x^7 + x^3 + 1 (the x^7 term is implicit in the shift)
   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam int FRAME_LEN     = 48;   // command frame and short response
   localparam int RESP_LONG_LEN = 136;  // R2 response
   localparam int CRC_SPAN      = 40;   // bits covered by CRC7 in a 48-bit frame

endpackage

// File: rtl/sd_cmd_phy_if.sv
// Command-controller and pad-side signal bundle for sd_cmd_phy.
// Latency: n/a (wires only).
// Backpressure: none; start is a strobe accepted only while busy is low.
// slave modport is the framer; master modport is the controller/pad model driving it.
interface sd_cmd_phy_if;
   import sd_cmd_phy_pkg::*;

   logic                     start;
   logic [5:0]               cmd_index;
   logic [31:0]              cmd_arg;
   logic [1:0]               resp_type;
   logic                     busy;
   logic                     done;
   logic                     timeout;
   logic                     crc_error;
   logic [RESP_LONG_LEN-1:0] response;
   logic                     pad_enable;
   logic                     pad_output_input;
   logic                     pad_data_out;
   logic                     pad_data_in;

   modport master (
      output start, cmd_index, cmd_arg, resp_type, pad_data_in,
      input  busy, done, timeout, crc_error, response,
             pad_enable, pad_output_input, pad_data_out
   );

   modport slave (
      input  start, cmd_index, cmd_arg, resp_type, pad_data_in,
      output busy, done, timeout, crc_error, response,
             pad_enable, pad_output_input, pad_data_out
   );

endinterface

// File: rtl/sd_cmd_phy_crc7.sv
// Serial CRC7 accumulator, one bit per enabled cycle, MSB-first data.
// Latency: crc_o reflects a bit one cycle after it is presented with enable_i.
// Backpressure: none; clear_i has priority over enable_i.
// Ports: clock_i, reset_i, clear_i, enable_i, bit_i in; crc_o[6:0] out.
module sd_cmd_phy_crc7
   import sd_cmd_phy_pkg::*;
(
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       clear_i,
   input  logic       enable_i,
   input  logic       bit_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb    = bit_i ^ crc_q[6];
      crc_d = crc_q;
      if (clear_i)
         crc_d = 7'h00;
      else if (enable_i)
         crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)
         crc_q <= 7'h00;
      else
         crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_phy.sv
// SD host CMD-line framer: sends a 48-bit command, then optionally captures a 48/136-bit response.
// Latency: done 50 cycles after start for no-response commands; otherwise after response or timeout.
// Backpressure: start is ignored while busy (including the done cycle).
// Ports: clock_i, reset_i (async, active-high); bus (sd_cmd_phy_if.slave) carries
//   controller handshake, status, response and the pad enable/direction/data signals.
module sd_cmd_phy
   import sd_cmd_phy_pkg::*;
#(
   parameter int TIMEOUT   = 64,
   parameter bit CRC_CHECK = 1'b1
)
(
   input  logic        clock_i,
   input  logic        reset_i,
   sd_cmd_phy_if.slave bus
);

   localparam int WCW = $clog2(TIMEOUT);

   state_e                   state_q, state_d;
   logic [7:0]               bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]           wait_cnt_q, wait_cnt_d, wait_nxt;
   logic [CRC_SPAN-1:0]      sh_q, sh_d;
   logic                     has_resp_q, has_resp_d;
   logic                     long_q, long_d;
   logic [RESP_LONG_LEN-1:0] resp_q, resp_d;
   logic                     timeout_q, timeout_d;
   logic                     crc_err_q, crc_err_d;

   logic       start_acc, tx_bit, tx_crc_en, rx_crc_en;
   logic [6:0] tx_crc, rx_crc;
   logic [7:0] rx_len;

   assign start_acc = (state_q == ST_IDLE) && bus.start;
   assign rx_len    = long_q ? 8'(RESP_LONG_LEN) : 8'(FRAME_LEN);
   assign wait_nxt  = wait_cnt_q + 1'b1;

   // Counter 47..8 carries start/dir/index/arg, 7..1 the CRC (MSB first), 0 the end bit.
   always_comb begin
      tx_bit = 1'b1;
      if (bit_cnt_q >= 8'd8)
         tx_bit = sh_q[CRC_SPAN-1];
      else if (bit_cnt_q != 8'd0)
         tx_bit = tx_crc[bit_cnt_q[2:0] - 3'd1];
   end

   assign tx_crc_en = (state_q == ST_TX) && (bit_cnt_q >= 8'd8);
   // Start bit is folded in on the WAIT->RX edge; RX then adds bits until 40 are covered.
   assign rx_crc_en = ((state_q == ST_WAIT_RESP) && !bus.pad_data_in) ||
                      ((state_q == ST_RX) && (bit_cnt_q < 8'(CRC_SPAN)));

   sd_cmd_phy_crc7 u_tx_crc (
      .clock_i (clock_i), .reset_i (reset_i), .clear_i (start_acc),
      .enable_i(tx_crc_en), .bit_i (sh_q[CRC_SPAN-1]), .crc_o (tx_crc)
   );

   sd_cmd_phy_crc7 u_rx_crc (
      .clock_i (clock_i), .reset_i (reset_i), .clear_i (start_acc),
      .enable_i(rx_crc_en), .bit_i (bus.pad_data_in), .crc_o (rx_crc)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         wait_cnt_q <= '0;
         sh_q       <= '0;
         has_resp_q <= 1'b0;
         long_q     <= 1'b0;
         resp_q     <= '0;
         timeout_q  <= 1'b0;
         crc_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         sh_q       <= sh_d;
         has_resp_q <= has_resp_d;
         long_q     <= long_d;
         resp_q     <= resp_d;
         timeout_q  <= timeout_d;
         crc_err_q  <= crc_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      wait_cnt_d = wait_cnt_q;
      sh_d       = sh_q;
      has_resp_d = has_resp_q;
      long_d     = long_q;
      resp_d     = resp_q;
      timeout_d  = timeout_q;
      crc_err_d  = crc_err_q;
      unique case (state_q)
         ST_IDLE: if (bus.start) begin
            sh_d       = {1'b0, 1'b1, bus.cmd_index, bus.cmd_arg};
            has_resp_d = (bus.resp_type == RESP_48) || (bus.resp_type == RESP_136);
            long_d     = (bus.resp_type == RESP_136);
            resp_d     = '0;
            timeout_d  = 1'b0;
            crc_err_d  = 1'b0;
            state_d    = ST_PRE;
         end
         ST_PRE: begin
            bit_cnt_d = 8'(FRAME_LEN - 1);
            state_d   = ST_TX;
         end
         ST_TX: begin
            if (bit_cnt_q >= 8'd8)
               sh_d = sh_q << 1;
            if (bit_cnt_q == 8'd0)
               state_d = ST_TAIL;
            else
               bit_cnt_d = bit_cnt_q - 8'd1;
         end
         ST_TAIL: begin
            wait_cnt_d = '0;
            state_d    = has_resp_q ? ST_WAIT_RESP : ST_DONE;
         end
         ST_WAIT_RESP: begin
            if (!bus.pad_data_in) begin
               resp_d    = {resp_q[RESP_LONG_LEN-2:0], bus.pad_data_in};
               bit_cnt_d = 8'd1;
               state_d   = ST_RX;
            end else if (wait_nxt == WCW'(TIMEOUT - 1)) begin
               // the TAIL cycle plus TIMEOUT-1 wait cycles puts done TIMEOUT cycles after TAIL
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               wait_cnt_d = wait_nxt;
            end
         end
         ST_RX: begin
            resp_d    = {resp_q[RESP_LONG_LEN-2:0], bus.pad_data_in};
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_q + 8'd1 == rx_len) begin
               state_d = ST_DONE;
               // resp_q[6:0] here is received bits 7..1 (the end bit is still arriving)
               if (!long_q)
                  crc_err_d = CRC_CHECK && (rx_crc != resp_q[6:0]);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy             = (state_q != ST_IDLE);
      bus.done             = (state_q == ST_DONE);
      bus.pad_enable       = (state_q != ST_IDLE) && (state_q != ST_DONE);
      bus.pad_output_input = (state_q == ST_TX) || (state_q == ST_TAIL);
      bus.pad_data_out     = (state_q == ST_TX) ? tx_bit : 1'b1;
      bus.timeout          = timeout_q;
      bus.crc_error        = crc_err_q;
      bus.response         = resp_q;
   end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: command framing, short/long responses, CRC error,
// timeout, mid-transfer reset and ignored start pulses.
// Card side is driven directly on pad_data_in, one bit per cycle on the falling edge.
module tb_sd_cmd_phy;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sd_cmd_phy_if bus ();

   sd_cmd_phy #(.TIMEOUT(64), .CRC_CHECK(1'b1)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;

   localparam logic [47:0]  CMD0_FRAME = 48'h40_0000_0000_95;
   localparam logic [47:0]  CMD8_FRAME = 48'h48_0000_01AA_87;
   localparam logic [47:0]  R7_RESP    = 48'h08_0000_01AA_13;
   localparam logic [135:0] R2_RESP    = 136'h3F_1122334455667788_99AABBCCDDEEFF01;

   // Capture the first 48 bits driven while the pad is enabled in transmit direction.
   logic [47:0] cap;
   int          cap_n;
   always @(negedge clk) begin
      if (!bus.busy)
         cap_n = 0;
      else if (bus.pad_enable && bus.pad_output_input && cap_n < 48) begin
         cap   = {cap[46:0], bus.pad_data_out};
         cap_n = cap_n + 1;
      end
   end

   task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.cmd_index = idx;
      bus.cmd_arg   = arg;
      bus.resp_type = rt;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n, output bit ok);
      n = 0;
      while (!bus.done && n < max) begin
         @(negedge clk);
         n++;
      end
      ok = bus.done;
   endtask

   task automatic card_send(input logic [135:0] bits, input int len);
      for (int i = len - 1; i >= 0; i--) begin
         bus.pad_data_in = bits[i];
         @(negedge clk);
      end
      bus.pad_data_in = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.timeout, bus.crc_error, bus.pad_enable,
           bus.pad_output_input, bus.pad_data_out} !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000001",
                  {bus.busy, bus.done, bus.timeout, bus.crc_error, bus.pad_enable,
                   bus.pad_output_input, bus.pad_data_out});
      end
      checks++;
      if (bus.response !== 136'h0) begin
         errors++;
         $display("FAIL reset_response: got %h expected 0", bus.response);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_cmd0;
      int n; bit ok;
      start_cmd(6'd0, 32'h0, 2'b00);
      checks++;
      if ({bus.busy, bus.pad_enable, bus.pad_output_input} !== 3'b110) begin
         errors++;
         $display("FAIL cmd0_pre: busy/en/dir got %b expected 110",
                  {bus.busy, bus.pad_enable, bus.pad_output_input});
      end
      wait_done(200, n, ok);
      checks++;
      if (!ok || n != 50) begin
         errors++;
         $display("FAIL cmd0_done_latency: got ok=%0d cycles=%0d expected ok=1 cycles=50", ok, n);
      end
      checks++;
      if (cap !== CMD0_FRAME || cap_n != 48) begin
         errors++;
         $display("FAIL cmd0_frame: got %h (%0d bits) expected %h (48 bits)", cap, cap_n, CMD0_FRAME);
      end
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.pad_enable} !== 3'b000) begin
         errors++;
         $display("FAIL cmd0_idle: busy/done/en got %b expected 000",
                  {bus.busy, bus.done, bus.pad_enable});
      end
   endtask

   task automatic run_cmd8(input logic [47:0] card_bits, input bit exp_crc_err, input string tag);
      int n; bit ok;
      start_cmd(6'd8, 32'h1AA, 2'b01);
      repeat (52) @(negedge clk);
      checks++;
      if ({bus.pad_enable, bus.pad_output_input} !== 2'b10) begin
         errors++;
         $display("FAIL %s_wait_pad: en/dir got %b expected 10", tag,
                  {bus.pad_enable, bus.pad_output_input});
      end
      card_send({88'h0, card_bits}, 48);
      wait_done(10, n, ok);
      checks++;
      if (!ok || n != 0) begin
         errors++;
         $display("FAIL %s_done: got ok=%0d late=%0d expected ok=1 late=0", tag, ok, n);
      end
      checks++;
      if (bus.response !== {88'h0, card_bits}) begin
         errors++;
         $display("FAIL %s_response: got %h expected %h", tag, bus.response, card_bits);
      end
      checks++;
      if ({bus.crc_error, bus.timeout} !== {exp_crc_err, 1'b0}) begin
         errors++;
         $display("FAIL %s_status: crc/timeout got %b expected %b", tag,
                  {bus.crc_error, bus.timeout}, {exp_crc_err, 1'b0});
      end
      checks++;
      if (cap !== CMD8_FRAME) begin
         errors++;
         $display("FAIL %s_frame: got %h expected %h", tag, cap, CMD8_FRAME);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.response !== {88'h0, card_bits} || bus.crc_error !== exp_crc_err) begin
         errors++;
         $display("FAIL %s_hold: busy=%b crc=%b resp=%h expected busy=0 crc=%b resp=%h", tag,
                  bus.busy, bus.crc_error, bus.response, exp_crc_err, card_bits);
      end
   endtask

   task automatic test_cmd8;
      run_cmd8(R7_RESP, 1'b0, "cmd8");
   endtask

   task automatic test_crc_error;
      run_cmd8(R7_RESP ^ 48'h2, 1'b1, "crcerr");
   endtask

   task automatic test_timeout;
      int n; bit ok;
      start_cmd(6'd17, 32'h0, 2'b01);
      wait_done(300, n, ok);
      // TAIL occupies the cycle after edge 49; done follows 64 cycles later
      checks++;
      if (!ok || n != 113) begin
         errors++;
         $display("FAIL timeout_latency: got ok=%0d cycles=%0d expected ok=1 cycles=113", ok, n);
      end
      checks++;
      if ({bus.timeout, bus.crc_error} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_status: timeout/crc got %b expected 10", {bus.timeout, bus.crc_error});
      end
      checks++;
      if (bus.response !== 136'h0) begin
         errors++;
         $display("FAIL timeout_response: got %h expected 0", bus.response);
      end
   endtask

   task automatic test_r2;
      int n; bit ok;
      start_cmd(6'd2, 32'h0, 2'b10);
      repeat (55) @(negedge clk);
      card_send(R2_RESP, 136);
      wait_done(10, n, ok);
      checks++;
      if (!ok || n != 0) begin
         errors++;
         $display("FAIL r2_done: got ok=%0d late=%0d expected ok=1 late=0", ok, n);
      end
      checks++;
      if (bus.response !== R2_RESP) begin
         errors++;
         $display("FAIL r2_response: got %h expected %h", bus.response, R2_RESP);
      end
      checks++;
      if ({bus.crc_error, bus.timeout} !== 2'b00) begin
         errors++;
         $display("FAIL r2_status: crc/timeout got %b expected 00", {bus.crc_error, bus.timeout});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_tx;
      int dones;
      start_cmd(6'd0, 32'h0, 2'b00);
      repeat (28) @(negedge clk);   // TX bit 20
      checks++;
      if (bus.pad_output_input !== 1'b1) begin
         errors++;
         $display("FAIL midtx_in_tx: dir got %b expected 1", bus.pad_output_input);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.timeout, bus.crc_error, bus.pad_enable,
           bus.pad_output_input, bus.pad_data_out} !== 7'b0000001) begin
         errors++;
         $display("FAIL midtx_reset_outputs: got %b expected 0000001",
                  {bus.busy, bus.done, bus.timeout, bus.crc_error, bus.pad_enable,
                   bus.pad_output_input, bus.pad_data_out});
      end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL midtx_no_done: got %0d active cycles expected 0", dones);
      end
      test_cmd0();
   endtask

   task automatic test_back_to_back;
      int n; bit ok;
      start_cmd(6'd0, 32'h0, 2'b00);
      repeat (10) @(negedge clk);
      bus.start     = 1'b1;
      bus.cmd_index = 6'h3F;
      bus.cmd_arg   = 32'hFFFF_FFFF;
      bus.resp_type = 2'b01;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(200, n, ok);
      checks++;
      if (!ok || n != 39) begin
         errors++;
         $display("FAIL b2b_done_latency: got ok=%0d cycles=%0d expected ok=1 cycles=39", ok, n);
      end
      checks++;
      if (cap !== CMD0_FRAME || bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL b2b_frame: got %h timeout=%b expected %h timeout=0", cap, bus.timeout, CMD0_FRAME);
      end
      // start coinciding with done must also be dropped
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start_at_done: busy got %b expected 0", bus.busy);
      end
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.cmd_index   = '0;
      bus.cmd_arg     = '0;
      bus.resp_type   = '0;
      bus.pad_data_in = 1'b1;
      test_reset();
      test_cmd0();
      test_cmd8();
      test_crc_error();
      test_timeout();
      test_r2();
      test_reset_mid_tx();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
